// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared encodings and widths for the instruction-memory loader
package imem_loader_pkg;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;
  localparam int         HDR_W             = 8;
  localparam int         CSUM_W            = 8;
  localparam int         ADDR_W            = 8;
  localparam int         WORD_W            = 16;

  localparam logic [3:0] ST_IDLE  = 4'd0;
  localparam logic [3:0] ST_COUNT = 4'd1;
  localparam logic [3:0] ST_ADDR  = 4'd2;
  localparam logic [3:0] ST_HI    = 4'd3;
  localparam logic [3:0] ST_LO    = 4'd4;
  localparam logic [3:0] ST_WRITE = 4'd5;
  localparam logic [3:0] ST_CSUM  = 4'd6;
  localparam logic [3:0] ST_DONE  = 4'd7;
  localparam logic [3:0] ST_ERR   = 4'd8;

  typedef enum logic [3:0] {
    S_IDLE  = ST_IDLE,
    S_COUNT = ST_COUNT,
    S_ADDR  = ST_ADDR,
    S_HI    = ST_HI,
    S_LO    = ST_LO,
    S_WRITE = ST_WRITE,
    S_CSUM  = ST_CSUM,
    S_DONE  = ST_DONE,
    S_ERR   = ST_ERR
  } state_e;

  // Byte-accepting states; the one-cycle WRITE/DONE/ERR states stall the stream.
  function automatic logic state_ready(input state_e s);
    return !(s inside {S_WRITE, S_DONE, S_ERR});
  endfunction

  // States waiting on the host, where an idle gap counts toward a timeout.
  function automatic logic state_timed(input state_e s);
    return s inside {S_COUNT, S_ADDR, S_HI, S_LO, S_CSUM};
  endfunction

endpackage

// File: rtl/imem_loader_frame_timeout.sv
// rtl/imem_loader_frame_timeout.sv - idle-gap counter that flags a stalled frame
module frame_timeout #(
  parameter int CYCLES = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic kick,
  output logic expired
);

  localparam int             CW    = $clog2(CYCLES + 1);
  localparam logic [CW-1:0]  LIMIT = CW'(CYCLES);

  logic [CW-1:0] cnt_q, cnt_d;

  // Saturates at the limit so expired stays asserted until the FSM leaves.
  always_comb begin
    cnt_d = cnt_q;
    if (!enable || kick) begin
      cnt_d = '0;
    end else if (cnt_q != LIMIT) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = enable && (cnt_q == LIMIT);

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - framed byte stream to 16-bit instruction-memory writes, holds the core while loading
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE        = DEFAULT_SYNC_BYTE,
  parameter int         TIMEOUT_CYCLES   = 1024,
  parameter logic       HOLD_AFTER_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [HDR_W-1:0]  in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [WORD_W-1:0] imem_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [HDR_W-1:0]    count_q, count_d;
  logic [7:0]          hi_q, hi_d;
  logic [CSUM_W-1:0]   csum_q, csum_d;
  logic                in_ready_q, in_ready_d;
  logic                imem_we_q, imem_we_d;
  logic [ADDR_W-1:0]   imem_addr_q, imem_addr_d;
  logic [WORD_W-1:0]   imem_wdata_q, imem_wdata_d;
  logic                cpu_hold_q, cpu_hold_d;
  logic                load_done_q, load_done_d;
  logic                load_err_q, load_err_d;

  logic                xfer;
  logic                expired;
  logic [CSUM_W-1:0]   csum_final;

  assign xfer = in_valid && in_ready_q;

  frame_timeout #(
    .CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .enable  (state_timed(state_q)),
    .kick    (xfer),
    .expired (expired)
  );

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    count_d      = count_q;
    hi_d         = hi_q;
    csum_d       = csum_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    cpu_hold_d   = cpu_hold_q;
    load_done_d  = 1'b0;
    load_err_d   = load_err_q;
    csum_final   = csum_q + in_data;

    case (state_q)
      S_IDLE: begin
        if (xfer && (in_data == SYNC_BYTE)) begin
          state_d    = S_COUNT;
          cpu_hold_d = 1'b1;
          load_err_d = 1'b0;
          csum_d     = '0;
        end
      end
      S_COUNT: begin
        if (expired) begin
          state_d = S_ERR;
        end else if (xfer) begin
          count_d = in_data;
          csum_d  = csum_final;
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        if (expired) begin
          state_d = S_ERR;
        end else if (xfer) begin
          addr_d  = in_data;
          csum_d  = csum_final;
          state_d = S_HI;
        end
      end
      S_HI: begin
        if (expired) begin
          state_d = S_ERR;
        end else if (xfer) begin
          hi_d    = in_data;
          csum_d  = csum_final;
          state_d = S_LO;
        end
      end
      S_LO: begin
        if (expired) begin
          state_d = S_ERR;
        end else if (xfer) begin
          csum_d       = csum_final;
          imem_we_d    = 1'b1;
          imem_addr_d  = addr_q;
          imem_wdata_d = {hi_q, in_data};
          state_d      = S_WRITE;
        end
      end
      S_WRITE: begin
        // COUNT of zero wraps through 255 and so yields 256 words.
        addr_d  = addr_q + 8'd1;
        count_d = count_q - 8'd1;
        state_d = (count_q == 8'd1) ? S_CSUM : S_HI;
      end
      S_CSUM: begin
        if (expired) begin
          state_d = S_ERR;
        end else if (xfer) begin
          state_d = (csum_final == '0) ? S_DONE : S_ERR;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Status outputs are registered against the state being entered.
    if (state_d == S_DONE) begin
      load_done_d = 1'b1;
      cpu_hold_d  = 1'b0;
    end
    if (state_d == S_ERR) begin
      load_err_d = 1'b1;
    end
    in_ready_d = state_ready(state_d);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      count_q      <= '0;
      hi_q         <= '0;
      csum_q       <= '0;
      in_ready_q   <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      cpu_hold_q   <= HOLD_AFTER_RESET;
      load_done_q  <= 1'b0;
      load_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      count_q      <= count_d;
      hi_q         <= hi_d;
      csum_q       <= csum_d;
      in_ready_q   <= in_ready_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      cpu_hold_q   <= cpu_hold_d;
      load_done_q  <= load_done_d;
      load_err_q   <= load_err_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign cpu_hold   = cpu_hold_q;
  assign load_done  = load_done_q;
  assign load_err   = load_err_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed scoreboard bench for imem_loader
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [15:0] imem_wdata;
  logic        cpu_hold;
  logic        load_done;
  logic        load_err;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int low_cnt = 0;
  int write_cnt = 0;

  logic [23:0] sb[$];
  logic [15:0] words[256];

  always #5 clk = ~clk;

  imem_loader dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .load_done  (load_done),
    .load_err   (load_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (imem_we === 1'b1) begin
        write_cnt++;
        check("we_blocks_ready", {31'd0, in_ready}, 32'd0);
        check("write_expected", {31'd0, sb.size() > 0}, 32'd1);
        if (sb.size() > 0) check("write_addr_data", {8'd0, imem_addr, imem_wdata}, {8'd0, sb.pop_front()});
      end
      if (load_done === 1'b1) done_cnt++;
      if (in_ready === 1'b0) low_cnt++;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    while (in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("byte_accept_timeout", 32'(n), 32'd0);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic send_frame(input int n, input logic [7:0] addr, input logic [7:0] delta);
    logic [7:0] sum, a, cnt;
    cnt = n[7:0];
    sum = cnt + addr;
    a   = addr;
    send_byte(8'hA5);
    send_byte(cnt);
    send_byte(addr);
    for (int i = 0; i < n; i++) begin
      sb.push_back({a, words[i]});
      a = a + 8'd1;
      sum = sum + words[i][15:8] + words[i][7:0];
      send_byte(words[i][15:8]);
      send_byte(words[i][7:0]);
    end
    send_byte(8'h00 - sum + delta);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int prev_done;
    int prev_writes;
    reset    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_outputs", {imem_we, imem_addr, imem_wdata, cpu_hold, load_done, load_err},
          {1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 1'b0});
    reset = 1'b1;
    @(negedge clk);
    check("ready_after_rst", {31'd0, in_ready}, 32'd1);

    // Basic two-word frame
    words[0] = 16'h1234; words[1] = 16'hABCD;
    send_frame(2, 8'h10, 8'h00);
    check("f1_done", 32'(done_cnt), 32'd1);
    check("f1_hold_err", {30'd0, cpu_hold, load_err}, 32'd0);
    check("f1_sb_empty", 32'(sb.size()), 32'd0);

    // Address wrap
    words[0] = 16'h5A5A; words[1] = 16'h0F0F;
    send_frame(2, 8'hFF, 8'h00);
    check("wrap_done", 32'(done_cnt), 32'd2);
    check("wrap_sb_empty", 32'(sb.size()), 32'd0);

    // Checksum off by one
    words[0] = 16'h1234; words[1] = 16'hABCD;
    send_frame(2, 8'h10, 8'h01);
    check("bad_csum_done", 32'(done_cnt), 32'd2);
    check("bad_csum_hold_err", {30'd0, cpu_hold, load_err}, 32'd3);
    check("bad_csum_sb_empty", 32'(sb.size()), 32'd0);

    // Timeout after the HI byte
    prev_writes = write_cnt;
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h20);
    send_byte(8'h77);
    check("sync_clears_err", {31'd0, load_err}, 32'd0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (load_err !== 1'b1 && n < 1100);
    check("timeout_fired", {31'd0, (n >= 1024) && (n <= 1027)}, 32'd1);
    check("timeout_hold", {31'd0, cpu_hold}, 32'd1);
    check("timeout_no_write", 32'(write_cnt), 32'(prev_writes));
    send_frame(2, 8'h10, 8'h00);
    check("after_timeout_done", 32'(done_cnt), 32'd3);
    check("after_timeout_err", {30'd0, cpu_hold, load_err}, 32'd0);

    // Junk before sync, sync value as data
    low_cnt = 0;
    send_byte(8'h00);
    send_byte(8'hA4);
    send_byte(8'hFF);
    words[0] = 16'hA512; words[1] = 16'h34A5;
    send_frame(2, 8'h40, 8'h00);
    check("junk_done", 32'(done_cnt), 32'd4);
    check("junk_ready_low", 32'(low_cnt), 32'd3);
    check("junk_sb_empty", 32'(sb.size()), 32'd0);

    // COUNT = 0 loads 256 words
    for (int i = 0; i < 256; i++) words[i] = 16'(i * 16'h0101 + 16'h3C00);
    prev_writes = write_cnt;
    send_frame(256, 8'h80, 8'h00);
    check("c256_writes", 32'(write_cnt - prev_writes), 32'd256);
    check("c256_done", 32'(done_cnt), 32'd5);

    // Reset asserted while in LO
    prev_done = done_cnt;
    prev_writes = write_cnt;
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h30);
    send_byte(8'h99);
    #3 reset = 1'b0;
    #1;
    check("midrst_outputs", {in_ready, imem_we, imem_addr, imem_wdata, cpu_hold, load_done, load_err},
          {1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 1'b0});
    repeat (3) @(negedge clk);
    check("midrst_no_we", {31'd0, imem_we}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_ready", {31'd0, in_ready}, 32'd1);
    check("midrst_no_write", 32'(write_cnt), 32'(prev_writes));
    words[0] = 16'hBEEF;
    send_frame(1, 8'h50, 8'h00);
    check("midrst_frame_done", 32'(done_cnt - prev_done), 32'd1);
    check("midrst_frame_state", {29'd0, cpu_hold, load_err, 1'b0}, 32'd0);
    check("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
